// File: rtl/fb_pipectrl_pkg.sv
// Shared definitions for the fb_pipectrl pipeline controller.
// Contents: the FSM state type, the register-number, timeout-counter and
// word widths, the default parameter values, and the load-use hazard helper.
package fb_pipectrl_pkg;

   // Controller states.
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } fb_state_e;

   // Widths.
   localparam int unsigned FB_32BITS = 32;
   localparam int unsigned FB_REG_W  = 5;
   localparam int unsigned FB_TCNT_W = 8;

   // Default parameter values.
   localparam int unsigned FB_TIMEOUT_DEF = 255;
   localparam int unsigned FB_CNT_W_DEF   = 16;

   // A load in EX writes a register that ID reads.
   // Register x0 is hard-wired to zero, so it never creates a hazard.
   function automatic logic fb_load_use(
      input logic                mem_to_reg,
      input logic [FB_REG_W-1:0] rd,
      input logic [FB_REG_W-1:0] rs1,
      input logic [FB_REG_W-1:0] rs2
   );
      return mem_to_reg && (rd != '0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/fb_pipectrl_satcnt.sv
// fb_satcnt: an up-counter that saturates at all-ones and has a synchronous clear.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       synchronous clear; it takes priority over inc
//   inc       increment request for this cycle
//   cnt       current count
module fb_satcnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/fb_pipectrl.sv
// fb_pipectrl: hazard, stall and flush controller for a 5-stage pipeline,
// with a data-memory wait FSM and saturating performance counters.
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   id_rs1, id_rs2               source registers of the instruction in ID
//   ex_mem_to_reg, ex_register_rd  load flag and destination register of the instruction in EX
//   ex_branch_taken              branch or jump resolved taken in EX
//   imem_ack                     fetch data is valid this cycle
//   mem_req, dmem_ack            data-memory request from MEM and its completion
//   perf_clr                     synchronous clear of the performance counters
//   pc_we..memwb_we              write enables for the PC and the pipeline registers
//   ifid_flush, idex_flush       load a bubble into IF/ID or ID/EX
//   dmem_req, mem_timeout        data-memory request and a one-cycle abort pulse
//   stall_cnt, flush_cnt         saturating counts of PC-stall cycles and branch flushes
module fb_pipectrl
   import fb_pipectrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = FB_TIMEOUT_DEF,
   parameter int unsigned CNT_W   = FB_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             ex_mem_to_reg,
   input  logic [4:0]       ex_register_rd,
   input  logic             ex_branch_taken,
   input  logic             imem_ack,
   input  logic             mem_req,
   input  logic             dmem_ack,
   input  logic             perf_clr,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             idex_we,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             dmem_req,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [FB_TCNT_W-1:0] TIMEOUT_V = TIMEOUT[FB_TCNT_W-1:0];

   fb_state_e            state_q, state_d;
   logic [FB_TCNT_W-1:0] tcnt_q, tcnt_d;

   logic freeze;
   logic dmem_req_c;
   logic mem_timeout_c;
   logic load_use;
   logic stall_inc;
   logic flush_inc;

   // Memory-wait FSM: computes the next state, the wait counter and freeze.
   always_comb begin
      state_d       = state_q;
      tcnt_d        = tcnt_q;
      freeze        = 1'b0;
      dmem_req_c    = 1'b0;
      mem_timeout_c = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_req) begin
               dmem_req_c = 1'b1;
               if (!dmem_ack) begin
                  freeze  = 1'b1;
                  state_d = ST_MEM_WAIT;
                  tcnt_d  = '0;
               end
            end
         end
         ST_MEM_WAIT: begin
            // An ack on the timeout cycle wins: the access completes normally.
            if (dmem_ack) begin
               dmem_req_c = 1'b1;
               state_d    = ST_RUN;
            end else if (tcnt_q == TIMEOUT_V) begin
               mem_timeout_c = 1'b1;
               state_d       = ST_RUN;
            end else begin
               dmem_req_c = 1'b1;
               freeze     = 1'b1;
               tcnt_d     = tcnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign load_use = fb_load_use(ex_mem_to_reg, ex_register_rd, id_rs1, id_rs2);

   // Hazard and priority decode. Every output is gated by rst, so a reset
   // asserted mid-access drops dmem_req without waiting for a clock edge.
   always_comb begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      dmem_req    = 1'b0;
      mem_timeout = 1'b0;
      if (!rst) begin
         dmem_req    = dmem_req_c;
         mem_timeout = mem_timeout_c;
         // A branch arriving while frozen stays in EX (EX/MEM holds), so
         // its flush takes effect on the release cycle.
         if (!freeze) begin
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            memwb_we = 1'b1;
            if (ex_branch_taken) begin
               pc_we      = 1'b1;
               ifid_we    = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (load_use || !imem_ack) begin
               idex_flush = 1'b1;
            end else begin
               pc_we   = 1'b1;
               ifid_we = 1'b1;
            end
         end
      end
   end

   assign stall_inc = !rst && !pc_we;
   assign flush_inc = !rst && !freeze && ex_branch_taken;

   fb_satcnt #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (perf_clr),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   fb_satcnt #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .clr (perf_clr),
      .inc (flush_inc),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_fb_pipectrl.sv
// Directed testbench for fb_pipectrl (TIMEOUT overridden to 4).
// ctl packs {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, dmem_req, mem_timeout}.
module tb_fb_pipectrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_register_rd;
   logic        ex_mem_to_reg, ex_branch_taken, imem_ack, mem_req, dmem_ack, perf_clr;
   logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
   logic        ifid_flush, idex_flush, dmem_req, mem_timeout;
   logic [15:0] stall_cnt, flush_cnt;
   logic [8:0]  ctl;

   int errors = 0;
   int checks = 0;

   // Expected control patterns.
   localparam logic [8:0] C_RESET = 9'b00000_00_0_0;
   localparam logic [8:0] C_IDLE  = 9'b11111_00_0_0;
   localparam logic [8:0] C_STALL = 9'b00111_01_0_0;
   localparam logic [8:0] C_BR    = 9'b11111_11_0_0;
   localparam logic [8:0] C_FRZ   = 9'b00000_00_1_0;
   localparam logic [8:0] C_ACK   = 9'b11111_00_1_0;
   localparam logic [8:0] C_ACKBR = 9'b11111_11_1_0;
   localparam logic [8:0] C_TMO   = 9'b11111_00_0_1;

   always #5 clk = ~clk;

   assign ctl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                 ifid_flush, idex_flush, dmem_req, mem_timeout};

   fb_pipectrl #(.TIMEOUT(4), .CNT_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .ex_mem_to_reg   (ex_mem_to_reg),
      .ex_register_rd  (ex_register_rd),
      .ex_branch_taken (ex_branch_taken),
      .imem_ack        (imem_ack),
      .mem_req         (mem_req),
      .dmem_ack        (dmem_ack),
      .perf_clr        (perf_clr),
      .pc_we           (pc_we),
      .ifid_we         (ifid_we),
      .idex_we         (idex_we),
      .exmem_we        (exmem_we),
      .memwb_we        (memwb_we),
      .ifid_flush      (ifid_flush),
      .idex_flush      (idex_flush),
      .dmem_req        (dmem_req),
      .mem_timeout     (mem_timeout),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs then change 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = 5'd1; id_rs2 = 5'd2; ex_register_rd = 5'd3;
      ex_mem_to_reg = 1'b0; ex_branch_taken = 1'b0; imem_ack = 1'b1;
      mem_req = 1'b0; dmem_ack = 1'b0; perf_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #2;
      chk("rst_ctl", 32'(ctl), 32'(C_RESET));
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      chk("rst_flush", 32'(flush_cnt), 32'd0);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("idle", 32'(ctl), 32'(C_IDLE));
      tick();
      chk("idle_stall", 32'(stall_cnt), 32'd0);

      // Load-use on rs2.
      ex_mem_to_reg = 1'b1; ex_register_rd = 5'd5; id_rs2 = 5'd5;
      #1 chk("lu_rs2", 32'(ctl), 32'(C_STALL));
      tick();
      chk("lu_stall", 32'(stall_cnt), 32'd1);
      // Load to x0 is not a hazard.
      ex_register_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
      #1 chk("lu_x0", 32'(ctl), 32'(C_IDLE));
      tick();
      // Non-load writing a read register is not a hazard.
      ex_mem_to_reg = 1'b0; ex_register_rd = 5'd7; id_rs1 = 5'd7;
      #1 chk("noload", 32'(ctl), 32'(C_IDLE));
      tick();
      chk("noload_stall", 32'(stall_cnt), 32'd1);

      // Branch beats a load-use on rs1.
      ex_mem_to_reg = 1'b1; ex_branch_taken = 1'b1;
      #1 chk("br_lu", 32'(ctl), 32'(C_BR));
      tick();
      chk("br_flushcnt", 32'(flush_cnt), 32'd1);
      chk("br_stall", 32'(stall_cnt), 32'd1);
      idle_inputs();

      // Fetch miss.
      imem_ack = 1'b0;
      #1 chk("imiss", 32'(ctl), 32'(C_STALL));
      tick();
      chk("imiss_stall", 32'(stall_cnt), 32'd2);
      imem_ack = 1'b1;

      // Three wait cycles, ack on the fourth, with a taken branch held across the freeze.
      mem_req = 1'b1; ex_branch_taken = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         #1 chk("wait_frz", 32'(ctl), 32'(C_FRZ));
         tick();
      end
      chk("wait_flushcnt", 32'(flush_cnt), 32'd1);
      dmem_ack = 1'b1;
      #1 chk("wait_ack", 32'(ctl), 32'(C_ACKBR));
      tick();
      chk("wait_stall", 32'(stall_cnt), 32'd5);
      chk("wait_flushcnt2", 32'(flush_cnt), 32'd2);
      idle_inputs();
      #1 chk("wait_back_run", 32'(ctl), 32'(C_IDLE));
      tick();

      // Zero-wait access stays in RUN.
      mem_req = 1'b1; dmem_ack = 1'b1;
      #1 chk("zw_ack", 32'(ctl), 32'(C_ACK));
      tick();
      mem_req = 1'b0; dmem_ack = 1'b0;
      #1 chk("zw_run", 32'(ctl), 32'(C_IDLE));
      tick();

      // Timeout: five frozen cycles, then an abort pulse.
      mem_req = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         #1 chk("to_frz", 32'(ctl), 32'(C_FRZ));
         tick();
      end
      #1 chk("to_pulse", 32'(ctl), 32'(C_TMO));
      tick();
      mem_req = 1'b0;
      #1 chk("to_after", 32'(ctl), 32'(C_IDLE));
      chk("to_stall", 32'(stall_cnt), 32'd10);
      tick();

      // Ack on the timeout cycle takes priority.
      mem_req = 1'b1;
      for (int unsigned i = 0; i < 5; i++) tick();
      dmem_ack = 1'b1;
      #1 chk("to_ack_prio", 32'(ctl), 32'(C_ACK));
      tick();
      idle_inputs();
      chk("to_ack_stall", 32'(stall_cnt), 32'd15);

      // Reset mid-wait.
      mem_req = 1'b1;
      tick(); tick();
      chk("mw_dreq", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("mw_rst_dreq", 32'(dmem_req), 32'd0);
      chk("mw_rst_ctl", 32'(ctl), 32'(C_RESET));
      chk("mw_rst_stall", 32'(stall_cnt), 32'd0);
      chk("mw_rst_flush", 32'(flush_cnt), 32'd0);
      tick();
      rst = 1'b0; mem_req = 1'b0;
      #1 chk("post_rst", 32'(ctl), 32'(C_IDLE));
      tick();
      chk("post_rst_stall", 32'(stall_cnt), 32'd0);

      // Saturation and clear.
      imem_ack = 1'b0;
      for (int unsigned i = 0; i < 65534; i++) tick();
      chk("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
      tick();
      chk("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);
      tick();
      chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
      perf_clr = 1'b1;
      tick();
      chk("clr_stall", 32'(stall_cnt), 32'd0);
      perf_clr = 1'b0;
      tick();
      chk("clr_resume", 32'(stall_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fb_pipectrl.md
FB_PIPECTRL -- requirements
Module: fb_pipectrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles MEM_WAIT holds before abort (8-bit counter).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
REQ-006 ex_mem_to_reg  in  1  instruction in EX is a load.
REQ-007 ex_register_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_branch_taken  in  1  branch or jump resolved taken in EX.
REQ-009 imem_ack  in  1  instruction fetch data valid this cycle.
REQ-010 mem_req  in  1  instruction in MEM needs a data-memory access.
REQ-011 dmem_ack  in  1  data memory completes the access this cycle.
REQ-012 perf_clr  in  1  synchronous clear of both performance counters.
REQ-013 pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  write enables for PC and the four pipeline registers.
REQ-014 ifid_flush, idex_flush  out  1 each  load a bubble (control fields zeroed) into IF/ID or ID/EX.
REQ-015 dmem_req  out  1  data-memory request, held until dmem_ack or timeout.
REQ-016 mem_timeout  out  1  one-cycle pulse on data-memory abort.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  saturating counts of PC-stall cycles and branch flushes.

Function
REQ-018 FSM states: RUN, MEM_WAIT; encoding local to the module.
REQ-019 freeze = (state==RUN && mem_req && !dmem_ack) || (state==MEM_WAIT && !dmem_ack && tcnt!=TIMEOUT); freeze forces all five write enables and both flushes to 0.
REQ-020 dmem_req = 1 in RUN while mem_req=1, and in MEM_WAIT; 0 otherwise; zero-wait access (ack in the request cycle) completes without leaving RUN.
REQ-021 RUN -> MEM_WAIT when mem_req && !dmem_ack; tcnt cleared to 0 on entry and incremented each MEM_WAIT cycle.
REQ-022 MEM_WAIT -> RUN on dmem_ack: that cycle freeze=0 and memwb_we=1, so MEM/WB captures the returned data.
REQ-023 MEM_WAIT -> RUN when tcnt==TIMEOUT without ack: mem_timeout=1 for that cycle, dmem_req=0, pipeline released; an ack in the same cycle takes priority and mem_timeout stays 0.
REQ-024 load_use = ex_mem_to_reg && ex_register_rd!=0 && (ex_register_rd==id_rs1 || ex_register_rd==id_rs2).
REQ-025 When not frozen: exmem_we=memwb_we=idex_we=1.
REQ-026 Priority when not frozen: ex_branch_taken > load_use > !imem_ack.
REQ-027 ex_branch_taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1; load_use is ignored.
REQ-028 load_use: pc_we=0, ifid_we=0, idex_flush=1.
REQ-029 !imem_ack (no branch, no load_use): pc_we=0, ifid_we=0, idex_flush=1.
REQ-030 Otherwise: pc_we=ifid_we=1 and both flushes 0.
REQ-031 A taken branch that arrives during freeze is not lost: EX/MEM is frozen, so the branch is still in EX when the pipeline releases and its flush applies in the release cycle.
REQ-032 stall_cnt increments in each cycle with pc_we=0.
REQ-033 flush_cnt increments in each non-frozen cycle with ex_branch_taken=1.
REQ-034 Both counters saturate at all-ones.
REQ-035 perf_clr takes priority over increment; the counter reads 0 in the next cycle.
REQ-036 All write-enable, flush, dmem_req and mem_timeout outputs are combinational from state, tcnt and inputs; there is no added latency.

Reset
REQ-037 While rst=1: state=RUN, tcnt=0, stall_cnt=flush_cnt=0, and all write enables, flushes, dmem_req and mem_timeout forced to 0.
REQ-038 rst asserted in MEM_WAIT abandons the access; dmem_req deasserts immediately (asynchronously).
REQ-039 After rst deasserts, the first posedge behaves as RUN with no pending request.

Structure
REQ-040 The following go in the shared defines file: FSM state constants, the `FB_32BITS-style width macros, and the default TIMEOUT value.
REQ-041 The hazard and priority decode is one combinational always block in the same module.
REQ-042 One sub-module: fb_satcnt (saturating counter with clear), instantiated twice for stall_cnt and flush_cnt.

Verification
REQ-043 Load x5 in EX with id_rs2=5 -> pc_we=0, ifid_we=0, idex_flush=1 for one cycle, stall_cnt +1; with rd=0 -> no stall.
REQ-044 ex_branch_taken=1 with load_use=1 -> ifid_flush=1, idex_flush=1, pc_we=1, flush_cnt +1, no stall.
REQ-045 mem_req=1, dmem_ack after 3 cycles -> all write enables 0 for 3 cycles, dmem_req=1 for 4 cycles, memwb_we=1 in the ack cycle, state returns to RUN.
REQ-046 mem_req=1 with dmem_ack never asserted, TIMEOUT=4 -> mem_timeout pulses once after 5 wait cycles, dmem_req drops, pipeline advances.
REQ-047 rst asserted mid MEM_WAIT -> dmem_req=0 immediately, counters 0; after release, idle RUN with all write enables 1 given imem_ack=1.
REQ-048 Force 65535 stall cycles, then one more -> stall_cnt stays 0xFFFF; perf_clr -> 0 in the next cycle.
